// File: rtl/operand_fwd_pipe_if.sv
// Bundle between issue/decode, the register file and the
// operand forwarding / load-use hazard unit.
interface operand_fwd_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NRD    = 2
);
    logic                    issue_valid;
    logic                    issue_we;
    logic [REG_AW-1:0]       issue_dst;
    logic                    issue_is_load;
    logic [DATA_W-1:0]       issue_data;
    logic                    mem_wr;
    logic [DATA_W-1:0]       mem_data;
    logic [NRD*REG_AW-1:0]   rd_addr;
    logic [NRD-1:0]          rd_en;
    logic [NRD*DATA_W-1:0]   rf_rdata;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic                    stall;
    logic                    wb_en;
    logic [REG_AW-1:0]       wb_dst;
    logic [DATA_W-1:0]       wb_data;
    logic                    load_err;
    logic [15:0]             stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_dst,
        output issue_is_load, issue_data,
        output mem_wr, mem_data,
        output rd_addr, rd_en, rf_rdata,
        input  rd_data, stall,
        input  wb_en, wb_dst, wb_data,
        input  load_err, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_dst,
        input  issue_is_load, issue_data,
        input  mem_wr, mem_data,
        input  rd_addr, rd_en, rf_rdata,
        output rd_data, stall,
        output wb_en, wb_dst, wb_data,
        output load_err, stall_cnt
    );
endinterface

// File: rtl/operand_fwd_pipe.sv
// Operand forwarding and load-use hazard unit: tracks DEPTH
// in-flight writes, forwards newest values, drives RF writeback.
module operand_fwd_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2
) (
    input logic               clk,
    input logic               rst_n,
    operand_fwd_pipe_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
        logic              rdy;
    } slot_t;

    slot_t                 r_slot   [DEPTH];
    slot_t                 w_filled [DEPTH-1];
    slot_t                 w_new;
    slot_t                 w_ret;
    logic                  w_fill_hit;
    logic [IDX_W-1:0]      w_fill_idx;
    logic [REG_AW-1:0]     w_addr   [NRD];
    logic [NRD-1:0]        w_hazard;
    logic [NRD*DATA_W-1:0] w_rd_data;
    logic                  w_stall;
    logic                  r_load_err;
    logic [15:0]           r_stall_cnt;

    // Returning load data belongs to the oldest unready slot.
    always_comb begin
        w_fill_hit = 1'b0;
        w_fill_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_slot[i].valid && !r_slot[i].rdy) begin
                w_fill_hit = 1'b1;
                w_fill_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH-1; i++) begin
            w_filled[i] = r_slot[i];
            if (bus.mem_wr && w_fill_hit &&
                w_fill_idx == IDX_W'(i)) begin
                w_filled[i].data = bus.mem_data;
                w_filled[i].rdy  = 1'b1;
            end
        end
    end

    always_comb begin
        w_new = '0;
        if (bus.issue_valid && !w_stall) begin
            w_new.valid = 1'b1;
            w_new.we    = bus.issue_we;
            w_new.dst   = bus.issue_dst;
            w_new.rdy   = !bus.issue_is_load;
            w_new.data  = bus.issue_is_load ? '0 : bus.issue_data;
        end
    end

    // Scan oldest to newest so the youngest match overrides.
    always_comb begin
        w_rd_data = bus.rf_rdata;
        w_hazard  = '0;
        for (int p = 0; p < NRD; p++) begin
            w_addr[p] = bus.rd_addr[p*REG_AW +: REG_AW];
            for (int i = DEPTH-1; i >= 0; i--) begin
                if (r_slot[i].valid && r_slot[i].we &&
                    r_slot[i].dst == w_addr[p]) begin
                    w_rd_data[p*DATA_W +: DATA_W] =
                        r_slot[i].rdy ? r_slot[i].data : '0;
                    w_hazard[p] = !r_slot[i].rdy;
                end
            end
            if (w_addr[p] == '0) begin
                w_rd_data[p*DATA_W +: DATA_W] = '0;
                w_hazard[p] = 1'b0;
            end
        end
    end

    assign w_stall = |(bus.rd_en & w_hazard);
    assign w_ret   = r_slot[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_load_err  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_slot[0] <= w_new;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= w_filled[i-1];
            end
            if (w_ret.valid && w_ret.we && !w_ret.rdy) begin
                r_load_err <= 1'b1;
            end
            if (w_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.rd_data   = w_rd_data;
    assign bus.stall     = w_stall;
    assign bus.wb_en     = w_ret.valid && w_ret.we &&
                           (w_ret.dst != '0);
    assign bus.wb_dst    = w_ret.dst;
    assign bus.wb_data   = w_ret.data;
    assign bus.load_err  = r_load_err;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: doc/operand_fwd_pipe.md
# operand_fwd_pipe

Parametrised operand-forwarding and load-use hazard unit for the pipelined CPU. It tracks the last DEPTH in-flight register writes between issue and register-file writeback, and returns the newest value for every source operand at any lookahead distance (1-, 2- or DEPTH-ahead). It raises a stall only when that value is a load result not yet returned. It sits between decode/issue and the register file, and its retire slot drives the register-file write port.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; register 0 is hardwired zero
- DEPTH, 3, in-flight slots between issue and writeback (≥2)
- NRD, 2, number of source-operand read ports

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction issues this cycle; ignored while stall=1
- issue_we  in  1  issued instruction writes a register
- issue_dst  in  REG_AW  destination register
- issue_is_load  in  1  result comes from memory later; issue_data ignored
- issue_data  in  DATA_W  ALU result of the issuing instruction
- mem_wr  in  1  load data returning this cycle
- mem_data  in  DATA_W  returned load data
- rd_addr  in  NRD*REG_AW  source register per port, port p at [p*REG_AW +: REG_AW]
- rd_en  in  NRD  port p is actually used by the issuing instruction
- rf_rdata  in  NRD*DATA_W  register-file read data per port
- rd_data  out  NRD*DATA_W  resolved operand per port
- stall  out  1  hold issue stage this cycle
- wb_en  out  1  retire slot commits
- wb_dst  out  REG_AW  retire destination
- wb_data  out  DATA_W  retire data
- load_err  out  1  sticky: an unready load reached retire
- stall_cnt  out  16  saturating stall-cycle counter

## Operation
- Slot i holds {valid, we, dst, data, rdy}. Slot 0 is youngest; slot DEPTH-1 is the retire slot.
- Every clock edge, all slots shift: s[i+1] ← s[i].
- s[0] ← issued entry if issue_valid && !stall, else a bubble (valid=0).
- Issued entry: rdy = !issue_is_load; data = issue_data, or 0 for loads.
- mem_wr: the oldest valid slot with rdy=0 takes data=mem_data and rdy=1. This is applied in the same edge as the shift, so the entry lands in its next slot already ready.
- mem_wr with no unready slot is ignored.
- Operand resolution, per port p, combinational:
  - rd_addr=0 → rd_data=0.
  - Otherwise, search s[0]..s[DEPTH-1] newest first for the first slot with valid && we && dst==rd_addr.
  - Match with rdy=1 → slot data.
  - Match with rdy=0 → hazard_p, and rd_data=0.
  - No match → rf_rdata.
- Newest match always wins (arbitration): an older write to the same register is never selected.
- stall = OR over p of (rd_en[p] && hazard_p). This is combinational, so no stall occurs in a cycle with no unready match.
- Retire: wb_en = s[DEPTH-1].valid && we && dst≠0; wb_dst/wb_data = slot fields.
- Writes to register 0 never assert wb_en and are never forwarded.
- If the retire slot is valid, we=1 and rdy=0: wb_en still asserts with data 0, and load_err sets and remains set until reset.
- stall_cnt increments on each edge where stall=1, and saturates at 0xFFFF.

## Timing
- Reset asserted (low): asynchronously clears all slots to invalid, load_err=0 and stall_cnt=0. Outputs go to wb_en=0, wb_dst=0, wb_data=0, stall=0, and rd_data=rf_rdata (or 0 for address 0).
- Reset mid-operation discards all in-flight writes; no writeback occurs for them.
- Forwarding latency is 0 cycles: an ALU result issued in cycle n is visible to an operand read in cycle n+1.
- Writeback occurs DEPTH cycles after issue; wb_* are valid in the cycle the entry sits in s[DEPTH-1].
- Load-use timing, with load data returned in the cycle after issue:
  - A 1-ahead consumer sees 1 stall cycle.
  - A 2-ahead consumer sees 0 stall cycles.
- Simultaneous same-cycle write and read of the same register: the in-flight (newest) slot wins over rf_rdata.
- Stall holds issue only. Older slots keep advancing and a bubble enters s[0].

## Test plan
- Preload rf with R2=20, R3=30, R8=80. Issue add $1,$2,$3 (data 50), then add $5,$1,$8 → port returns 50 (1-ahead), no stall, and $5 data 130 retires on schedule.
- Issue add $9 (210), one unrelated add, then read $9 → 2-ahead forward gives 210; wb_dst=9, wb_data=210 appear DEPTH cycles after issue.
- Issue $1←60, then $1←50, then read $1 → 50 (newest wins); the two writebacks retire in order, 60 then 50.
- Issue add $0 with data 70, then read $0 → 0; wb_en stays 0 for that entry.
- Issue a load to $4, return mem_data=4 in the next cycle, with the consumer reading $4 1-ahead → stall=1 for exactly 1 cycle, then 4; stall_cnt=1.
- Issue a load and never assert mem_wr → load_err=1 when it retires. Then assert Reset mid-stream → all slots clear, wb_en=0 immediately, stall_cnt=0.
